ad_upack: RTL and testbench
===========================

// Module: ad_upack
// PURPOSE
//  Width-down/up unpacker: accepts words of I_W units and emits words of O_W units (units UNIT_W bits).
//  Unit order is preserved; unit 0 is the LSB unit of each word on both sides.
//  Sits between a DMA/bus-side producer and a fixed-width sample consumer. Upstream has ready/valid.
//  Downstream is valid-only: no backpressure.
// PARAMETERS
//  I_W     4   units per input word (>=1)
//  O_W     3   units per output word (>=1)
//  UNIT_W  8   bits per unit
// PORTS
//  clk     in   1           single clock, all logic on rising edge
//  reset   in   1           asynchronous, active-low reset (asserted when 0)
//  idata   in   I_W*UNIT_W  input word
//  ivalid  in   1           idata valid; beat transfers when ivalid & iready
//  iready  out  1           block can accept a beat this cycle
//  odata   out  O_W*UNIT_W  output word, registered
//  ovalid  out  1           odata valid for exactly this cycle (one-cycle pulse per word)
// BEHAVIOUR
//  - Internal buffer of CAP = I_W+O_W-1 units; cnt = buffered units, width $clog2(CAP+1).
//  - Reset (async): cnt=0, ovalid=0, odata=0, buffer cleared; iready=0 while reset asserted.
//  - Per clock edge:
//    - emit = (cnt >= O_W).
//    - If emit: odata <= buffer units [0..O_W-1]; ovalid <= 1; remaining units shift down by O_W.
//    - Otherwise ovalid <= 0 and odata holds.
//    - rem = emit ? cnt-O_W : cnt.
//    - iready = (rem < O_W), computed combinationally from cnt.
//    - On ivalid & iready, the I_W units of idata are appended at unit position rem.
//    - cnt_next = rem + (accept ? I_W : 0); this never exceeds CAP.
//  - Latency: at most one output per cycle. A word completed at edge k gives ovalid high after edge k+1.
//  - Throughput: if I_W <= O_W, a continuous input stream is never stalled.
//  - Throughput: if I_W > O_W, iready drops until the buffer drains below O_W units.
//  - Simultaneous emit and accept in the same cycle is legal and required for full throughput.
//  - ivalid while iready=0: beat is ignored, no state change.
//  - Trailing units (< O_W) remain buffered until more input arrives; there is no flush.
//  - Reset mid-stream discards all buffered units; the first beat after reset starts at unit 0.
// CONFIGURATION
//  - Macro AD_UPACK_PROTO_CHECK_EN defined:
//    - Adds output port `ierror` (1 bit).
//    - ierror is sticky; it is set the cycle after any ivalid=1 while iready=0, and cleared only by reset.
//  - Macro not defined: ierror port absent; ignored beats are silent.
// STRUCTURE
//  - Package ad_upack_pkg:
//    - CAP and CNT_W derivation functions (clog2).
//    - No typedefs needed beyond unit-vector widths.
//  - One natural sub-module: ad_upack_shreg.
//    - Unit-granular buffer with shift-down-by-O_W and append-at-rem.
//  - The top level holds the count/handshake logic and the output registers.
// TESTING (I_W=6, O_W=4, UNIT_W=8 unless noted; byte n of stream = n[7:0])
//  1. Continuous ivalid=1, 1024-byte ramp:
//     - First beat 0x050403020100.
//     - Outputs 0x03020100, 0x07060504, 0x0B0A0908 ...
//     - The collected output stream equals the input byte-for-byte.
//  2. Same ramp with random ivalid gaps (50%): identical output stream; ovalid never when cnt<O_W.
//  3. Random data, random gaps: output bytes match input for every complete O_W word.
//  4. iready check:
//     - After one beat (cnt 6 -> emit, rem 2), iready=1.
//     - With I_W=8, O_W=2: iready low for 3 cycles after each accepted beat.
//  5. Reset asserted mid-stream after 3 beats:
//     - ovalid=0, odata=0, cnt=0 immediately.
//     - Next beat 0xAA.. yields first output starting at unit 0.
//  6. I_W=2, O_W=4, continuous input:
//     - ovalid every second cycle.
//     - iready stays 1 throughout.
//     - With AD_UPACK_PROTO_CHECK_EN, ierror remains 0.

Source files
------------

// File: rtl/ad_upack_pkg.sv
// ad_upack_pkg: sizing helpers shared by the ad_upack unpacker and its buffer.
//   cap_units : buffer depth in units, enough for a partial output word plus one input beat
//   cnt_width : bits needed to count 0..cap units
package ad_upack_pkg;

  function automatic int unsigned cap_units(input int unsigned i_w, input int unsigned o_w);
    return i_w + o_w - 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned cap);
    return $clog2(cap + 1);
  endfunction

endpackage

// File: rtl/ad_upack_shreg.sv
// ad_upack_shreg: unit-granular buffer for ad_upack.
// Each cycle it optionally drops the O_W head units (shift) and then optionally
// writes I_W units at unit position rem (load). Unit 0 is the LSB unit.
// Ports:
//   clk, reset  clock, async active-low reset (clears the buffer)
//   shift       drop the head O_W units this cycle
//   load        write din at unit position rem (after the shift)
//   rem         unit index where din lands
//   din         I_W-unit input word
//   head        current O_W head units (from the register, not the next state)
module ad_upack_shreg
  import ad_upack_pkg::*;
#(
  parameter int unsigned I_W    = 4,
  parameter int unsigned O_W    = 3,
  parameter int unsigned UNIT_W = 8,
  localparam int unsigned CAP   = cap_units(I_W, O_W),
  localparam int unsigned CNT_W = cnt_width(CAP)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    shift,
  input  logic                    load,
  input  logic [CNT_W-1:0]        rem,
  input  logic [I_W*UNIT_W-1:0]   din,
  output logic [O_W*UNIT_W-1:0]   head
);

  localparam int unsigned BW   = CAP * UNIT_W;
  localparam int unsigned IW_B = I_W * UNIT_W;

  logic [BW-1:0] mem_q;
  logic [BW-1:0] mem_d;
  logic [BW-1:0] shifted;
  logic [BW-1:0] ins;
  logic [BW-1:0] mask;

  // Shift-down first, then splice the new beat in at rem via a positioned mask.
  always_comb begin
    shifted = shift ? (mem_q >> (O_W * UNIT_W)) : mem_q;
    ins     = BW'(din) << (32'(rem) * UNIT_W);
    mask    = BW'({IW_B{1'b1}}) << (32'(rem) * UNIT_W);
    mem_d   = load ? ((shifted & ~mask) | ins) : shifted;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign head = mem_q[O_W*UNIT_W-1:0];

endmodule

// File: rtl/ad_upack.sv
// ad_upack: width unpacker, I_W-unit input beats to O_W-unit output words,
// unit order preserved (unit 0 = LSB unit). Ready/valid upstream, valid-only
// downstream (no backpressure).
// Optional build macro AD_UPACK_PROTO_CHECK_EN adds a sticky ierror output that
// flags any beat offered while iready is low.
// Ports:
//   clk      clock, rising edge
//   reset    async active-low reset
//   idata    input word, I_W units
//   ivalid   input beat valid; transfers on ivalid & iready
//   iready   combinational: block can take a beat this cycle (low in reset)
//   odata    registered output word, O_W units
//   ovalid   one-cycle pulse per output word
//   ierror   (AD_UPACK_PROTO_CHECK_EN only) sticky protocol violation flag
module ad_upack
  import ad_upack_pkg::*;
#(
  parameter int unsigned I_W    = 4,
  parameter int unsigned O_W    = 3,
  parameter int unsigned UNIT_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [I_W*UNIT_W-1:0] idata,
  input  logic                  ivalid,
  output logic                  iready,
  output logic [O_W*UNIT_W-1:0] odata,
  output logic                  ovalid
`ifdef AD_UPACK_PROTO_CHECK_EN
  ,
  output logic                  ierror
`endif
);

  localparam int unsigned CAP   = cap_units(I_W, O_W);
  localparam int unsigned CNT_W = cnt_width(CAP);

  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      rem;
  logic [CNT_W-1:0]      cnt_next;
  logic                  emit;
  logic                  accept;
  logic [O_W*UNIT_W-1:0] head;

  // Emit whenever a full word is buffered; room for a beat exists once the
  // post-emit remainder is below one output word, so cnt never exceeds CAP.
  always_comb begin
    emit     = (cnt >= CNT_W'(O_W));
    rem      = emit ? (cnt - CNT_W'(O_W)) : cnt;
    iready   = reset & (rem < CNT_W'(O_W));
    accept   = ivalid & iready;
    cnt_next = rem + (accept ? CNT_W'(I_W) : CNT_W'(0));
  end

  ad_upack_shreg #(
    .I_W    (I_W),
    .O_W    (O_W),
    .UNIT_W (UNIT_W)
  ) u_shreg (
    .clk   (clk),
    .reset (reset),
    .shift (emit),
    .load  (accept),
    .rem   (rem),
    .din   (idata),
    .head  (head)
  );

  // Count and output registers; odata holds between words.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      ovalid <= 1'b0;
      odata  <= '0;
    end else begin
      cnt    <= cnt_next;
      ovalid <= emit;
      if (emit) begin
        odata <= head;
      end
    end
  end

`ifdef AD_UPACK_PROTO_CHECK_EN
  // Sticky flag for beats offered while the block is not ready.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ierror <= 1'b0;
    end else if (ivalid && !iready) begin
      ierror <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ad_upack.sv
// tb_ad_upack: directed/table bench for ad_upack.
// DUT a: I_W=6, O_W=4, UNIT_W=8. DUT b: I_W=2, O_W=4, UNIT_W=8.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_ad_upack;

  logic        clk;
  logic        reset;
  logic [47:0] idata_a;
  logic        ivalid_a;
  logic        iready_a;
  logic [31:0] odata_a;
  logic        ovalid_a;
  logic [15:0] idata_b;
  logic        ivalid_b;
  logic        iready_b;
  logic [31:0] odata_b;
  logic        ovalid_b;
`ifdef AD_UPACK_PROTO_CHECK_EN
  logic        ierror_a;
  logic        ierror_b;
`endif

  ad_upack #(.I_W(6), .O_W(4), .UNIT_W(8)) dut_a (
    .clk    (clk),
    .reset  (reset),
    .idata  (idata_a),
    .ivalid (ivalid_a),
    .iready (iready_a),
    .odata  (odata_a),
    .ovalid (ovalid_a)
`ifdef AD_UPACK_PROTO_CHECK_EN
    ,
    .ierror (ierror_a)
`endif
  );

  ad_upack #(.I_W(2), .O_W(4), .UNIT_W(8)) dut_b (
    .clk    (clk),
    .reset  (reset),
    .idata  (idata_b),
    .ivalid (ivalid_b),
    .iready (iready_b),
    .odata  (odata_b),
    .ovalid (ovalid_b)
`ifdef AD_UPACK_PROTO_CHECK_EN
    ,
    .ierror (ierror_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] q[$];
  int         words;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b0;
    ivalid_a = 1'b0;
    ivalid_b = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Scoreboard: every ovalid on DUT a must retire 4 queued bytes in order.
  task automatic collect_a();
    logic [31:0] exp;
    if (ovalid_a) begin
      check("ovalid_with_full_word", 64'(q.size() >= 4), 64'd1);
      if (q.size() >= 4) begin
        for (int k = 0; k < 4; k++) exp[k*8 +: 8] = q.pop_front();
        check("stream_word", 64'(odata_a), 64'(exp));
      end
      words++;
    end
  endtask

  // mode 0: ramp, continuous; mode 1: ramp, random gaps; mode 2: random data, random gaps
  task automatic run_stream(input int mode, input int n_beats);
    logic [47:0] cur;
    logic        have;
    int          beats;
    int          nbyte;
    int          sent;
    beats = 0;
    nbyte = 0;
    sent  = 0;
    have  = 1'b0;
    words = 0;
    q.delete();
    for (int c = 0; c < n_beats * 4 + 100 && beats < n_beats; c++) begin
      @(negedge clk);
      collect_a();
      if (!have) begin
        for (int k = 0; k < 6; k++) begin
          cur[k*8 +: 8] = (mode == 2) ? 8'($urandom) : 8'(nbyte);
          nbyte++;
        end
        have = 1'b1;
      end
      ivalid_a = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      idata_a  = cur;
      if (ivalid_a && iready_a) begin
        for (int k = 0; k < 6; k++) q.push_back(cur[k*8 +: 8]);
        sent += 6;
        have  = 1'b0;
        beats++;
      end
    end
    check("beats_sent", 64'(beats), 64'(n_beats));
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      ivalid_a = 1'b0;
      collect_a();
    end
    check("word_count", 64'(words), 64'(sent / 4));
    check("trailing_units", 64'(q.size()), 64'(sent % 4));
  endtask

  typedef struct {
    logic        ivalid;
    logic [47:0] idata;
    logic        iready;
    logic        ovalid;
    logic [31:0] odata;
  } vec_t;

  vec_t tv[11];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    // Row i: expected outputs before driving row i's inputs.
    tv[0]  = '{1'b1, 48'h050403020100, 1'b1, 1'b0, 32'h00000000};
    tv[1]  = '{1'b1, 48'h0B0A09080706, 1'b1, 1'b0, 32'h00000000};
    tv[2]  = '{1'b1, 48'h11100F0E0D0C, 1'b0, 1'b1, 32'h03020100};
    tv[3]  = '{1'b1, 48'h11100F0E0D0C, 1'b1, 1'b1, 32'h07060504};
    tv[4]  = '{1'b0, 48'h000000000000, 1'b1, 1'b1, 32'h0B0A0908};
    tv[5]  = '{1'b0, 48'h000000000000, 1'b1, 1'b1, 32'h0F0E0D0C};
    tv[6]  = '{1'b1, 48'h171615141312, 1'b1, 1'b0, 32'h0F0E0D0C};
    tv[7]  = '{1'b0, 48'h000000000000, 1'b0, 1'b0, 32'h0F0E0D0C};
    tv[8]  = '{1'b0, 48'h000000000000, 1'b1, 1'b1, 32'h13121110};
    tv[9]  = '{1'b0, 48'h000000000000, 1'b1, 1'b1, 32'h17161514};
    tv[10] = '{1'b0, 48'h000000000000, 1'b1, 1'b0, 32'h17161514};

    reset    = 1'b0;
    idata_a  = '0;
    ivalid_a = 1'b0;
    idata_b  = '0;
    ivalid_b = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_iready", 64'(iready_a), 64'd0);
    check("reset_ovalid", 64'(ovalid_a), 64'd0);
    check("reset_odata", 64'(odata_a), 64'd0);
`ifdef AD_UPACK_PROTO_CHECK_EN
    check("reset_ierror", 64'(ierror_a), 64'd0);
`endif
    reset = 1'b1;

    // Table: handshake, emit+accept overlap, held beat while not ready, odata hold.
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      check($sformatf("tv%0d_iready", i), 64'(iready_a), 64'(tv[i].iready));
      check($sformatf("tv%0d_ovalid", i), 64'(ovalid_a), 64'(tv[i].ovalid));
      check($sformatf("tv%0d_odata", i), 64'(odata_a), 64'(tv[i].odata));
      ivalid_a = tv[i].ivalid;
      idata_a  = tv[i].idata;
    end
`ifdef AD_UPACK_PROTO_CHECK_EN
    check("ierror_sticky", 64'(ierror_a), 64'd1);
`endif

    // Streams: 171 beats = 1026 bytes covers the 1024-byte ramp.
    do_reset();
    run_stream(0, 171);
    do_reset();
    run_stream(1, 171);
    do_reset();
    run_stream(2, 120);

    // Reset mid-stream after three beats discards everything.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ivalid_a = 1'b1;
      idata_a  = 48'h0B0A09080706 + 48'(i);
    end
    @(negedge clk);
    ivalid_a = 1'b0;
    reset    = 1'b0;
    #1;
    check("midrst_ovalid", 64'(ovalid_a), 64'd0);
    check("midrst_odata", 64'(odata_a), 64'd0);
    check("midrst_iready", 64'(iready_a), 64'd0);
    @(negedge clk);
    reset    = 1'b1;
    ivalid_a = 1'b1;
    idata_a  = 48'hAAABACADAEAF;
    #1;
    check("post_rst_iready", 64'(iready_a), 64'd1);
    @(negedge clk);
    ivalid_a = 1'b0;
    check("post_rst_ovalid0", 64'(ovalid_a), 64'd0);
    @(negedge clk);
    check("post_rst_ovalid1", 64'(ovalid_a), 64'd1);
    check("post_rst_odata", 64'(odata_a), 64'hACADAEAF);
    @(negedge clk);
    check("post_rst_ovalid2", 64'(ovalid_a), 64'd0);
    check("post_rst_hold", 64'(odata_a), 64'hACADAEAF);

    // Narrow input (I_W=2, O_W=4): never stalled, output every second cycle.
    do_reset();
    begin
      int nb;
      int wb;
      logic [31:0] exp;
      nb = 0;
      wb = 0;
      ivalid_b = 1'b1;
      idata_b  = {8'(nb + 1), 8'(nb)};
      nb += 2;
      #1;
      check("narrow_iready0", 64'(iready_b), 64'd1);
      for (int k = 1; k <= 16; k++) begin
        @(negedge clk);
        check($sformatf("narrow_iready%0d", k), 64'(iready_b), 64'd1);
        check($sformatf("narrow_ovalid%0d", k), 64'(ovalid_b), 64'((k >= 3) && (k % 2 == 1)));
        if ((k >= 3) && (k % 2 == 1)) begin
          for (int j = 0; j < 4; j++) exp[j*8 +: 8] = 8'(wb * 4 + j);
          check($sformatf("narrow_odata%0d", k), 64'(odata_b), 64'(exp));
          wb++;
        end
        idata_b = {8'(nb + 1), 8'(nb)};
        nb += 2;
      end
      @(negedge clk);
      ivalid_b = 1'b0;
    end
`ifdef AD_UPACK_PROTO_CHECK_EN
    check("narrow_ierror", 64'(ierror_b), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
